// File: rtl/alu_ctrl_pipe.sv
// Registered ALU control decoder with valid/ready handshakes and multi-cycle MUL.
// Optional perf counters (perf_ops, perf_illegal) enabled by ALUCTRL_PERF_EN.
module alu_ctrl_pipe #(
    parameter int OPC_W      = 11,
    parameter int ALUOP_W    = 2,
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OPC_W-1:0]   opcode,
    input  logic [ALUOP_W-1:0] alu_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  alu_ctrl,
    output logic               illegal,
    output logic               mul_busy
`ifdef ALUCTRL_PERF_EN
    ,
    output logic [15:0]        perf_ops,
    output logic [15:0]        perf_illegal
`endif
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam bit MUL_MC = (MUL_CYCLES > 1);

    localparam logic [3:0] C_AND   = 4'b0000;
    localparam logic [3:0] C_ORR   = 4'b0001;
    localparam logic [3:0] C_ADD   = 4'b0010;
    localparam logic [3:0] C_EOR   = 4'b0011;
    localparam logic [3:0] C_SUB   = 4'b0110;
    localparam logic [3:0] C_PASSB = 4'b0111;
    localparam logic [3:0] C_LSL   = 4'b1000;
    localparam logic [3:0] C_LSR   = 4'b1001;
    localparam logic [3:0] C_MUL   = 4'b1010;

    typedef enum logic {
        IDLE,
        MUL_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic               ill_q, ill_d;

    logic [10:0]        r_opc;
    logic [9:0]         i_opc;
    logic [3:0]         dec_ctrl;
    logic               dec_ill;
    logic               dec_mul;
    logic               accept;
    logic               xfer;

    assign r_opc = opcode[OPC_W-1 -: 11];
    assign i_opc = opcode[OPC_W-1 -: 10];

    always_comb begin
        dec_ctrl = C_ADD;
        dec_ill  = 1'b0;
        dec_mul  = 1'b0;
        unique case (alu_op[1:0])
            2'b00: dec_ctrl = C_ADD;
            2'b01: dec_ctrl = C_PASSB;
            2'b10: begin
                case (r_opc)
                    11'b10001011000: dec_ctrl = C_ADD;
                    11'b11001011000: dec_ctrl = C_SUB;
                    11'b10001010000: dec_ctrl = C_AND;
                    11'b10101010000: dec_ctrl = C_ORR;
                    11'b11001010000: dec_ctrl = C_EOR;
                    11'b11010011011: dec_ctrl = C_LSL;
                    11'b11010011010: dec_ctrl = C_LSR;
                    11'b10011011000: begin
                        dec_ctrl = C_MUL;
                        dec_mul  = MUL_MC;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            2'b11: begin
                case (i_opc)
                    10'b1001000100: dec_ctrl = C_ADD;
                    10'b1101000100: dec_ctrl = C_SUB;
                    10'b1001001000: dec_ctrl = C_AND;
                    10'b1011001000: dec_ctrl = C_ORR;
                    default:        dec_ill  = 1'b1;
                endcase
            end
        endcase
    end

    // in_ready may read 1 during flush; the flush term blocks the accept.
    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready && !flush;
    assign xfer     = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        ill_d       = ill_q;
        if (flush) begin
            state_d     = IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (xfer) out_valid_d = 1'b0;
                    if (accept) begin
                        if (dec_mul) begin
                            state_d = MUL_WAIT;
                            cnt_d   = CNT_W'(MUL_CYCLES - 1);
                        end else begin
                            out_valid_d = 1'b1;
                            ctrl_d      = CTRL_W'(dec_ctrl);
                            ill_d       = dec_ill;
                        end
                    end
                end
                MUL_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                        ctrl_d      = CTRL_W'(C_MUL);
                        ill_d       = 1'b0;
                        state_d     = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            ctrl_q      <= CTRL_W'(C_ADD);
            ill_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            ill_q       <= ill_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_ctrl  = ctrl_q;
    assign illegal   = ill_q;
    assign mul_busy  = (state_q == MUL_WAIT);

`ifdef ALUCTRL_PERF_EN
    logic [15:0] perf_ops_q, perf_ops_d;
    logic [15:0] perf_ill_q, perf_ill_d;

    always_comb begin
        perf_ops_d = perf_ops_q;
        perf_ill_d = perf_ill_q;
        if (xfer && perf_ops_q != 16'hFFFF) perf_ops_d = perf_ops_q + 16'd1;
        if (xfer && ill_q && perf_ill_q != 16'hFFFF) perf_ill_d = perf_ill_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops_q <= '0;
            perf_ill_q <= '0;
        end else begin
            perf_ops_q <= perf_ops_d;
            perf_ill_q <= perf_ill_d;
        end
    end

    assign perf_ops     = perf_ops_q;
    assign perf_illegal = perf_ill_q;
`endif

endmodule
